// File: rtl/tlul_pkg.sv
// Shared TL-UL constants and the host port FSM state type.
package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;

  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // Host port transaction FSM
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

endpackage

// File: rtl/tlul_host_port.sv
// TL-UL host port with a single outstanding transaction.
// Optional response timeout: define TLUL_HOST_TIMEOUT_EN to enable a
// WAIT_RSP watchdog of TIMEOUT_CYC cycles that returns an error response.
module tlul_host_port
  import tlul_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SRC_W       = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  // command side
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  input  logic [3:0]        i_cmd_mask,
  // response side
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  // TL-UL A channel
  output logic              o_a_valid,
  input  logic              i_a_ready,
  output logic [2:0]        o_a_opcode,
  output logic [2:0]        o_a_param,
  output logic [1:0]        o_a_size,
  output logic [SRC_W-1:0]  o_a_source,
  output logic [ADDR_W-1:0] o_a_address,
  output logic [3:0]        o_a_mask,
  output logic [31:0]       o_a_data,
  // TL-UL D channel
  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic [2:0]        i_d_opcode,
  input  logic [SRC_W-1:0]  i_d_source,
  input  logic [31:0]       i_d_data,
  input  logic              i_d_error
);

  state_e             state_reg, state_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         mask_reg;
  logic [SRC_W-1:0]   src_reg;      // next source ID to issue
  logic [SRC_W-1:0]   out_src_reg;  // source ID of the outstanding request
  logic               rsp_valid_reg;
  logic [31:0]        rsp_rdata_reg;
  logic               rsp_err_reg;

  logic               cmd_fire;
  logic               a_fire;
  logic               d_fire;
  logic               d_match;
  logic               timeout;
  logic [2:0]         exp_d_opcode;

  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign a_fire       = o_a_valid && i_a_ready;
  assign d_fire       = i_d_valid && o_d_ready;
  assign d_match      = (state_reg == WAIT_RSP) && d_fire && (i_d_source == out_src_reg);
  // Writes are answered with AccessAck, reads with AccessAckData.
  assign exp_d_opcode = we_reg ? ACK : ACK_DATA;

`ifdef TLUL_HOST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_reg;

  assign timeout = (state_reg == WAIT_RSP) && !d_match &&
                   (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Count cycles spent waiting; cleared whenever not waiting.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg == WAIT_RSP) begin
      to_cnt_reg <= to_cnt_reg + CNT_W'(1);
    end else begin
      to_cnt_reg <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (cmd_fire) state_next = REQ;
      REQ:      if (i_a_ready) state_next = WAIT_RSP;
      WAIT_RSP: if (d_match || timeout) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs: handshakes and A-channel fields derived from the latched command.
  always_comb begin
    // No new command in the cycle the response pulse is presented.
    o_cmd_ready = i_reset_n && (state_reg == IDLE) && !rsp_valid_reg;
    // D is sunk in IDLE (stray beats) and WAIT_RSP, never while requesting.
    o_d_ready   = i_reset_n && (state_reg != REQ);
    o_a_valid   = (state_reg == REQ);
    o_a_param   = 3'd0;
    o_a_size    = 2'd2;
    o_a_source  = src_reg;
    o_a_address = addr_reg & ~ADDR_W'(3);
    if (we_reg) begin
      o_a_opcode = (mask_reg == 4'hF) ? PUT_FULL : PUT_PARTIAL;
      o_a_mask   = mask_reg;
      o_a_data   = wdata_reg;
    end else begin
      o_a_opcode = GET;
      o_a_mask   = 4'hF;
      o_a_data   = 32'd0;
    end
  end

  // Latch the command on acceptance; it stays frozen until the next one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mask_reg  <= '0;
    end else if (cmd_fire) begin
      we_reg    <= i_cmd_we;
      addr_reg  <= i_cmd_addr;
      wdata_reg <= i_cmd_wdata;
      mask_reg  <= i_cmd_mask;
    end
  end

  // Source counter advances per A handshake; remember the issued ID for matching.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      src_reg     <= '0;
      out_src_reg <= '0;
    end else if (a_fire) begin
      src_reg     <= src_reg + SRC_W'(1);
      out_src_reg <= src_reg;
    end
  end

  // One-cycle response pulse from a matching D beat or a timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (d_match) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= (i_d_opcode == ACK_DATA) ? i_d_data : 32'd0;
      rsp_err_reg   <= i_d_error || (i_d_opcode != exp_d_opcode);
    end else if (timeout) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b1;
    end else begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: doc/tlul_host_port.md
TLUL_HOST_PORT -- requirements
Module: tlul_host_port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning A-channel address width.
REQ-002 The block SHALL have parameter SRC_W, default 4, meaning source ID width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 256, meaning response timeout in cycles.
REQ-004 Port i_clk, input, 1 bit: the single clock.
REQ-005 Port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Command ports SHALL be: i_cmd_valid (in, 1), o_cmd_ready (out, 1), i_cmd_we (in, 1), i_cmd_addr (in, ADDR_W), i_cmd_wdata (in, 32) and i_cmd_mask (in, 4).
REQ-007 Response ports SHALL be: o_rsp_valid (out, 1, one-cycle pulse), o_rsp_rdata (out, 32) and o_rsp_err (out, 1).
REQ-008 A-channel ports SHALL be: o_a_valid (out, 1), i_a_ready (in, 1), o_a_opcode (out, 3), o_a_param (out, 3), o_a_size (out, 2), o_a_source (out, SRC_W), o_a_address (out, ADDR_W), o_a_mask (out, 4) and o_a_data (out, 32).
REQ-009 D-channel ports SHALL be: i_d_valid (in, 1), o_d_ready (out, 1), i_d_opcode (in, 3), i_d_source (in, SRC_W), i_d_data (in, 32) and i_d_error (in, 1).

Function
REQ-010 The block SHALL be a TL-UL host with one outstanding transaction, using FSM states IDLE, REQ and WAIT_RSP.
REQ-011 IDLE: o_cmd_ready=1; on i_cmd_valid, the block SHALL register the command and go to REQ on the next edge.
REQ-012 REQ: o_a_valid=1, and all A fields SHALL stay stable until the cycle in which i_a_ready=1; on that cycle the FSM SHALL go to WAIT_RSP.
REQ-013 Opcode selection: read -> Get (4); write with mask 4'hF -> PutFullData (0); other writes -> PutPartialData (1).
REQ-014 For reads, o_a_mask SHALL be 4'hF and o_a_data SHALL be 0.
REQ-015 o_a_param SHALL always be 0 and o_a_size SHALL always be 2.
REQ-016 o_a_address SHALL carry the registered address with bits [1:0] forced to 0.
REQ-017 o_a_source SHALL be an SRC_W counter that increments on each A handshake and wraps from all-ones to 0.
REQ-018 o_d_ready SHALL be 1 in WAIT_RSP and 1 in IDLE (stray beats are sunk), and 0 in REQ.
REQ-019 In WAIT_RSP, a D beat with i_d_source equal to the outstanding source SHALL produce o_rsp_valid=1 on the next cycle, with o_rsp_rdata=i_d_data for AccessAckData (1), else 0, and the FSM SHALL return to IDLE.
REQ-020 o_rsp_err SHALL be set on i_d_error, on an opcode mismatch (AccessAck vs AccessAckData relative to the request type), or on an opcode outside {0,1}.
REQ-021 A D beat whose source mismatches SHALL be accepted and dropped with no response.
REQ-022 Latency: command acceptance to o_a_valid SHALL be 1 cycle, and D handshake to o_rsp_valid SHALL be 1 cycle.
REQ-023 A new command SHALL NOT be accepted in the same cycle as o_rsp_valid is asserted; the earliest acceptance is the following cycle.

Reset
REQ-024 Asserting i_reset_n low SHALL immediately force: FSM=IDLE, source counter=0, o_a_valid=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_cmd_ready=0 while in reset, and o_d_ready=0.
REQ-025 A reset mid-transaction SHALL abandon it with no response; after reset release, a response to the abandoned transaction SHALL be dropped per REQ-021 only if its source mismatches.

Configuration
REQ-026 Macro TLUL_HOST_TIMEOUT_EN: when defined, a counter SHALL run in WAIT_RSP; after TIMEOUT_CYC cycles without a matching D beat, the block SHALL emit o_rsp_valid=1 with o_rsp_err=1 and o_rsp_rdata=0, and return to IDLE, and the late beat SHALL then be dropped because the source has advanced.
REQ-027 When TLUL_HOST_TIMEOUT_EN is undefined, WAIT_RSP SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-028 Package tlul_pkg SHALL hold the A opcode constants (GET=4, PUT_FULL=0, PUT_PARTIAL=1), the D opcode constants (ACK=0, ACK_DATA=1) and the FSM state enum.
REQ-029 The block SHALL be a single module with no sub-modules.

Verification
REQ-030 Write 0x0000_00A5 to address 0x10 with mask F and i_a_ready=1, followed by a D beat with AccessAck and matching source -> A opcode 0, address 0x10, data 0xA5; o_rsp_valid with err=0.
REQ-031 Read address 0x13 with i_a_ready low for 3 cycles -> A fields stable for 4 cycles, address 0x10, opcode 4; D AccessAckData 0x5A -> o_rsp_rdata=0x5A.
REQ-032 Write with mask 4'b0011 -> opcode 1; then a read answered with AccessAck -> o_rsp_err=1.
REQ-033 A D beat with a wrong source during WAIT_RSP -> no response; the following correct beat completes the transaction.
REQ-034 17 back-to-back commands with SRC_W=4 -> sources 0..15 then 0.
REQ-035 With TLUL_HOST_TIMEOUT_EN and TIMEOUT_CYC=8 and no D beat -> o_rsp_err=1 pulses 8 cycles after the A handshake.
